// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage in front of the decoder and immediate generator. It owns the
// fetch address, issues word requests to a variable-latency instruction
// memory, and holds the returned word on Instruction_bus_o until decode
// consumes it. Redirects from execute change the fetch address. Any fetch
// that is still in flight when a redirect arrives is drained and discarded.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   imem_req_o         fetch request, held until the memory answers
//   imem_addr_o        word-aligned fetch address (the address register)
//   imem_ready_i       memory response strobe; imem_rdata_i valid this cycle
//   imem_rdata_i       fetched instruction word
//   stall_i            decode is not consuming the held instruction
//   redirect_i         one-cycle request to change the fetch address
//   redirect_pc_i      redirect target (bits [1:0] forced to zero)
//   pc_o, pc_plus4_o   address of the held instruction, and that address + 4
//   Instruction_bus_o  held instruction, or NOP when nothing valid is held
//   op_o               opcode field of Instruction_bus_o
//   instr_valid_o      Instruction_bus_o carries a live fetched instruction
// ---------------------------------------------------------------------------
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] Instruction_bus_o,
  output logic [6:0]  op_o,
  output logic        instr_valid_o
);

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  // Low during reset and for one cycle after it. The request is gated
  // with this flop so that it stays off while reset is high without a
  // combinational path from reset to the memory interface.
  logic        run_q, run_d;

  logic [31:0] target;

  assign target = redirect_pc_i & 32'hFFFF_FFFC;

  // State register. All registers reset together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      addr_q    <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_q      <= RESET_PC;
      pending_q <= 32'h0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      run_q     <= run_d;
    end
  end

  // Next-state logic and datapath updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    run_d     = 1'b1;

    case (state_q)
      FETCH: begin
        if (!run_q) begin
          // No request is outstanding yet, so a redirect can be applied
          // directly to the address register.
          if (redirect_i) addr_d = target;
        end else if (imem_ready_i) begin
          if (redirect_i) begin
            addr_d = target;
          end else begin
            instr_d = imem_rdata_i;
            pc_d    = addr_q;
            state_d = HOLD;
          end
        end else if (redirect_i) begin
          // The request must stay stable until it completes, so the
          // target waits in the pending register.
          pending_d = target;
          state_d   = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          addr_d  = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          addr_d  = addr_q + 32'd4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ready_i) begin
          addr_d  = redirect_i ? target : pending_q;
          state_d = FETCH;
        end else if (redirect_i) begin
          pending_d = target;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Outputs come from registered state only.
  always_comb begin
    imem_req_o        = run_q && ((state_q == FETCH) || (state_q == DRAIN));
    imem_addr_o       = addr_q;
    instr_valid_o     = (state_q == HOLD);
    Instruction_bus_o = instr_valid_o ? instr_q : NOP_INSTR;
    op_o              = Instruction_bus_o[6:0];
    pc_o              = pc_q;
    pc_plus4_o        = pc_q + 32'd4;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. Every response the bench hands
// the fetch unit as a real instruction is queued with its expected pc, and
// that entry is popped when the instruction appears on the bus. Outputs are
// sampled 1ns after the rising edge. Inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] Instruction_bus_o;
  logic [6:0]  op_o;
  logic        instr_valid_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  txn_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ready_i      (imem_ready_i),
    .imem_rdata_i      (imem_rdata_i),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .Instruction_bus_o (Instruction_bus_o),
    .op_o              (op_o),
    .instr_valid_o     (instr_valid_o)
  );

  // 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] data,
                               input logic stall, input logic redir,
                               input logic [31:0] rpc);
    imem_ready_i  = rdy;
    imem_rdata_i  = data;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the held instruction against the oldest queued response.
  task automatic popCompare(input string tag);
    txn_t t;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_empty observed=%0d expected=%0d", tag, 0, 1);
    end else begin
      t = expQ.pop_front();
      checkOutput({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
      checkOutput({tag, "_pc"}, pc_o, t.pc);
      checkOutput({tag, "_pc4"}, pc_plus4_o, t.pc + 32'd4);
      checkOutput({tag, "_bus"}, Instruction_bus_o, t.instr);
      checkOutput({tag, "_op"}, {25'b0, op_o}, {25'b0, t.instr[6:0]});
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    txn_t        t;

    // Reset with every other input trying to interfere.
    reset = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_req", {31'b0, imem_req_o}, 32'd0);
    end
    checkOutput("rst_pc", pc_o, 32'h0040_0000);
    checkOutput("rst_pc4", pc_plus4_o, 32'h0040_0004);
    checkOutput("rst_bus", Instruction_bus_o, NOP);
    checkOutput("rst_op", {25'b0, op_o}, 32'h13);
    checkOutput("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("post_rst_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("post_rst_addr", imem_addr_o, 32'h0040_0000);

    // Zero-wait memory; valid every second cycle.
    for (int i = 0; i < 3; i++) begin
      a = 32'h0040_0000 + 32'(4 * i);
      d = a ^ 32'hA5A5_0000;
      checkOutput("zw_fetch_valid", {31'b0, instr_valid_o}, 32'd0);
      checkOutput("zw_fetch_bus", Instruction_bus_o, NOP);
      checkOutput("zw_req", {31'b0, imem_req_o}, 32'd1);
      checkOutput("zw_addr", imem_addr_o, a);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 32'h0);
      t.pc = a;
      t.instr = d;
      expQ.push_back(t);
      tick();
      popCompare("zw");
      checkOutput("zw_hold_req", {31'b0, imem_req_o}, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Three wait states, then a four-cycle stall.
    for (int i = 0; i < 3; i++) begin
      checkOutput("ws_addr", imem_addr_o, 32'h0040_000C);
      checkOutput("ws_req", {31'b0, imem_req_o}, 32'd1);
      checkOutput("ws_valid", {31'b0, instr_valid_o}, 32'd0);
      tick();
    end
    checkOutput("ws_addr_rdy", imem_addr_o, 32'h0040_000C);
    applyStimulus(1'b1, 32'h00C5_82B3, 1'b1, 1'b0, 32'h0);
    t.pc = 32'h0040_000C;
    t.instr = 32'h00C5_82B3;
    expQ.push_back(t);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    popCompare("ws");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      checkOutput("stall_bus", Instruction_bus_o, 32'h00C5_82B3);
      checkOutput("stall_pc", pc_o, 32'h0040_000C);
      checkOutput("stall_req", {31'b0, imem_req_o}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("after_stall_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("after_stall_addr", imem_addr_o, 32'h0040_0010);

    // Redirect from HOLD while stalled; low address bits dropped.
    applyStimulus(1'b1, 32'h0000_0093, 1'b1, 1'b0, 32'h0);
    t.pc = 32'h0040_0010;
    t.instr = 32'h0000_0093;
    expQ.push_back(t);
    tick();
    popCompare("rh");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0103);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rh_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("rh_bus", Instruction_bus_o, NOP);
    checkOutput("rh_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("rh_addr", imem_addr_o, 32'h0040_0100);

    // Redirects while the request is outstanding; latest target wins.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0200);
    tick();
    checkOutput("dr_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("dr_addr_held", imem_addr_o, 32'h0040_0100);
    checkOutput("dr_valid", {31'b0, instr_valid_o}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0300);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("dr_addr_held2", imem_addr_o, 32'h0040_0100);
    checkOutput("dr_valid2", {31'b0, instr_valid_o}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("dr_stale_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("dr_stale_bus", Instruction_bus_o, NOP);
    checkOutput("dr_req_new", {31'b0, imem_req_o}, 32'd1);
    checkOutput("dr_addr_new", imem_addr_o, 32'h0040_0300);

    // Same-cycle response and redirect in FETCH, then address wrap.
    applyStimulus(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    checkOutput("wr_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("wr_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h0000_0517, 1'b0, 1'b0, 32'h0);
    t.pc = 32'hFFFF_FFFC;
    t.instr = 32'h0000_0517;
    expQ.push_back(t);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    popCompare("wr");
    checkOutput("wr_pc4_zero", pc_plus4_o, 32'h0000_0000);
    tick();
    checkOutput("wr_next_req", {31'b0, imem_req_o}, 32'd1);
    checkOutput("wr_next_addr", imem_addr_o, 32'h0000_0000);
    checkOutput("wr_next_valid", {31'b0, instr_valid_o}, 32'd0);

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage that sits directly upstream of the immediate generator and decoder. It owns the program counter and issues word requests to a variable-latency instruction memory. It registers the returned word and presents it, together with its opcode field, as the instruction bus that the decode and immediate logic consume. It also accepts redirects (branch/jump targets) from the execute side and discards stale in-flight fetches.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base).
- NOP_INSTR, 32'h0000_0013, instruction word presented when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; overrides every other input.
- imem_req_o  output  1  fetch request to instruction memory.
- imem_addr_o  output  32  word-aligned fetch address; equals the address register.
- imem_ready_i  input  1  memory response strobe; data valid on imem_rdata_i this cycle.
- imem_rdata_i  input  32  fetched instruction word.
- stall_i  input  1  downstream not consuming the held instruction.
- redirect_i  input  1  one-cycle request to change fetch address.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced to 0).
- pc_o  output  32  address of the instruction on Instruction_bus_o.
- pc_plus4_o  output  32  pc_o + 4, modulo 2^32.
- Instruction_bus_o  output  32  held instruction, or NOP_INSTR when invalid.
- op_o  output  7  Instruction_bus_o[6:0].
- instr_valid_o  output  1  Instruction_bus_o holds a live fetched instruction.

## Operation
- Registers: fetch address register (addr_q), instruction register, pc register, pending-redirect register, 2-bit state.
- States: FETCH, HOLD, DRAIN.
- Memory protocol: while imem_req_o=1, imem_addr_o is held stable until imem_ready_i=1. A response is accepted only in a cycle with req=1 and ready=1. ready may be asserted in the same cycle as req (zero wait). ready with req=0 is ignored.
- FETCH: imem_req_o=1, imem_addr_o=addr_q.
  - ready=1, no redirect: capture rdata into the instruction register and addr_q into pc, set valid, go to HOLD.
  - ready=1 and redirect=1: discard rdata, addr_q<=target, stay in FETCH.
  - ready=0 and redirect=1: pending<=target, go to DRAIN.
  - ready=0, no redirect: stay in FETCH.
- HOLD: imem_req_o=0, instr_valid_o=1.
  - redirect=1, which has priority over stall: valid<=0, addr_q<=target, go to FETCH. The held instruction is dropped.
  - stall_i=1: hold all outputs unchanged.
  - stall_i=0: instruction is consumed. valid<=0, addr_q<=addr_q+4 (wraps at 2^32), go to FETCH.
- DRAIN: imem_req_o=1 with the old address held. A further redirect overwrites pending, and the latest redirect wins. When ready=1, discard rdata, addr_q<=pending (or the same-cycle redirect target if redirect=1), go to FETCH.
- Redirect target used everywhere is {redirect_pc_i[31:2],2'b00}.
- Invalid output: whenever instr_valid_o=0, Instruction_bus_o=NOP_INSTR and op_o=7'h13.
- Illegal state encoding: return to FETCH with valid=0.

## Timing
- Reset values:
  - state=FETCH, addr_q=RESET_PC, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - instr_valid_o=0, Instruction_bus_o=NOP_INSTR, op_o=7'h13, pending=0.
  - imem_req_o=0 while reset is high. imem_req_o=1 in the first cycle after reset deasserts.
- imem_req_o and imem_addr_o are decoded from registered state only, with no combinational path from any input.
- Latency: a response accepted in cycle N gives instr_valid_o=1 in cycle N+1.
- Throughput: at least 2 cycles per instruction (FETCH + HOLD) with zero-wait memory and no stall.
- Redirect in cycle N from HOLD or FETCH+ready: request to the target in cycle N+1.
- Redirect from DRAIN: request to the target in the cycle after the stale response.
- Reset mid-DRAIN or mid-FETCH: the outstanding response is abandoned. The memory must also be reset by the same signal.

## Test plan
- Reset: hold reset 3 cycles with redirect_i=1 and ready=1 -> req=0, pc_o=0x00400000, Instruction_bus_o=0x00000013, valid=0; req=1 with addr 0x00400000 in the cycle after release.
- Zero-wait sequence: ready tied 1, rdata=addr^0xA5A5_0000 -> valid pulses every 2nd cycle, pc_o = 0x00400000, 0x00400004, 0x00400008, matching data.
- Wait states plus stall: ready after 3 cycles, then stall_i=1 for 4 cycles -> addr held stable for the 3 wait cycles; Instruction_bus_o, pc_o and valid constant for the 4 stall cycles; next req to pc+4.
- Redirect in HOLD with stall=1, target 0x0040_0103 -> valid drops next cycle, next req addr 0x00400100.
- Redirect during an outstanding request (ready=0): redirect to 0x00400200, then to 0x00400300 while in DRAIN, ready 2 cycles later -> stale data is never presented (valid stays 0), next req addr 0x00400300.
- Wrap: redirect to 0xFFFF_FFFC, consume -> next req addr 0x0000_0000, pc_plus4_o=0x0000_0000 while holding 0xFFFF_FFFC.
